// File: rtl/seg7_pkg.sv
// Shared constants and types for the
// four-digit seven-segment scanner.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] DIG_OFF   = 4'hF;
  localparam int         DIV_DEF   = 5000;
  localparam int         BLANK_DEF = 2;

  typedef logic [1:0] idx_t;

  function automatic logic [3:0] dig_on(idx_t i);
    dig_on = ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Slot position counter: counts 0..DIV-1,
// flags the last position of every slot.
module seg7_prescaler
  import seg7_pkg::*;
#(
  parameter int DIV = DIV_DEF,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  assign wrap = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit segment driver with
// frame-synchronous shadow registers.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV   = DIV_DEF,
  parameter int BLANK = BLANK_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] nHEX0,
  input  logic [7:0] nHEX1,
  input  logic [7:0] nHEX2,
  input  logic [7:0] nHEX3,
  output logic [7:0] nSEG,
  output logic [3:0] nDIG,
  output logic       FRAME
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic          wrap;
  idx_t          idx;
  logic [7:0]    sh [4];
  logic [7:0]    hex [4];
  logic          primed;
  logic          load;
  logic          blank;
  logic [7:0]    seg_d;
  logic [3:0]    dig_d;

  seg7_prescaler #(
    .DIV (DIV),
    .CW  (CW)
  ) u_pre (
    .clk  (CLK),
    .rst  (RST),
    .cnt  (cnt),
    .wrap (wrap)
  );

  assign hex[0] = nHEX0;
  assign hex[1] = nHEX1;
  assign hex[2] = nHEX2;
  assign hex[3] = nHEX3;

  assign load = ~primed | (wrap & (idx == 2'd3));

  generate
    if (BLANK == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (cnt < CW'(BLANK));
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       idx <= '0;
    else if (wrap) idx <= idx + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      primed <= 1'b0;
      for (int i = 0; i < 4; i++) sh[i] <= SEG_OFF;
    end else if (load) begin
      primed <= 1'b1;
      for (int i = 0; i < 4; i++) sh[i] <= hex[i];
    end
  end

  // Before priming the shadows still hold reset
  // values, so the first digit is taken straight
  // from the inputs being loaded on that edge.
  always_comb begin
    dig_d = DIG_OFF;
    seg_d = SEG_OFF;
    if (!blank) begin
      dig_d = dig_on(idx);
      seg_d = primed ? sh[idx] : hex[idx];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nSEG  <= SEG_OFF;
      nDIG  <= DIG_OFF;
      FRAME <= 1'b0;
    end else begin
      nSEG  <= seg_d;
      nDIG  <= dig_d;
      FRAME <= load;
    end
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter DIV, default 5000, clock cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have parameter BLANK, default 2, anti-ghost blank cycles at the start of each slot; legal range 0..DIV-1.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports nHEX0..nHEX3  input  8 each  segment patterns, active-low, bit7 = DP; digit 0 is rightmost.
REQ-006 SHALL have port nSEG  output  8  multiplexed segment drive, active-low.
REQ-007 SHALL have port nDIG  output  4  digit enables, active-low, at most one bit low.
REQ-008 SHALL have port FRAME  output  1  one-cycle pulse marking a shadow-register load.

Function
REQ-009 SHALL hold a position counter cnt (0..DIV-1) that increments every cycle and wraps from DIV-1 to 0.
REQ-010 SHALL hold a digit index idx (0..3) that advances only on the cnt wrap, in the order 0,1,2,3,0.
REQ-011 SHALL hold four 8-bit shadow registers sh0..sh3 and a 1-bit primed flag.
REQ-012 SHALL load sh0..sh3 from nHEX0..nHEX3 together on the edge where cnt==DIV-1 and idx==3, so a frame never mixes old and new digits.
REQ-013 SHALL also load the shadows on the first edge after reset release (primed==0), then set primed to 1.
REQ-014 SHALL register nSEG, nDIG and FRAME, with one cycle of latency from the (cnt, idx, shadow) state.
REQ-015 For cnt<BLANK, the next-cycle outputs SHALL be nDIG=4'hF and nSEG=8'hFF.
REQ-016 For cnt>=BLANK, the next-cycle outputs SHALL be nDIG bit idx low with all other bits high, and nSEG=sh[idx].
REQ-017 FRAME SHALL be high for exactly the one cycle after each shadow load (REQ-012 and REQ-013), and low otherwise.
REQ-018 Input changes outside a load edge SHALL NOT affect nSEG.
REQ-019 With BLANK=0, every cycle SHALL drive a digit; nDIG SHALL never show two low bits, including on the slot-boundary cycle.

Reset
REQ-020 RST high SHALL immediately force: cnt=0, idx=0, primed=0, sh0..sh3=8'hFF, nSEG=8'hFF, nDIG=4'hF, FRAME=0.
REQ-021 Asserting RST mid-slot or mid-frame SHALL abandon the scan; after release, scanning SHALL restart at digit 0, position 0.
REQ-022 The first visible digit after release SHALL come from the REQ-013 load, not from the 8'hFF reset values.

Structure
REQ-023 Package seg7_pkg SHALL hold constants SEG_OFF=8'hFF and DIG_OFF=4'hF, the DIV/BLANK defaults, and the 2-bit digit-index type.
REQ-024 Sub-module seg7_prescaler SHALL implement cnt with parameter DIV and outputs cnt and wrap (high when cnt==DIV-1).
REQ-025 seg7_scan SHALL contain the index, shadow and output registers; expected size is 120-250 lines in total.

Verification (DIV=8, BLANK=2 unless stated)
REQ-026 Reset/prime: nHEX0..3 = C0,F9,A4,B0; release RST -> FRAME high 1 cycle after the first edge; slot 0 shows 2 cycles with nDIG=F, then 6 cycles with nDIG=E and nSEG=C0.
REQ-027 Full frame: same inputs -> nDIG sequence E,D,B,7 with nSEG C0,F9,A4,B0, each digit preceded by 2 blank cycles; period 32 cycles; FRAME repeats every 32 cycles.
REQ-028 Tear-free update: change nHEX0 to 99 while digit 2 is displayed -> digit 0 keeps showing C0 until the next frame load, then shows 99.
REQ-029 Mid-operation reset: assert RST for 1 cycle during digit 2 at cnt=5 -> outputs immediately F/FF; after release the scan restarts at digit 0 and priming occurs again.
REQ-030 BLANK=0, DIV=2: nDIG toggles E,E,D,D,B,B,7,7; it is never F after priming, and no cycle has two low bits.
REQ-031 An assertion SHALL check on every cycle that nDIG is F or has exactly one low bit, and that nDIG==F implies nSEG==FF.
